// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - up/down counter with wrap, saturate and one-shot modes
module mode_counter #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  state_t           state;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] wrap_next;
  logic [WIDTH-1:0] load_clamped;
  logic             at_term;
  logic             hit_term;

  // Terminal/start values follow the dir sampled on this edge, so a dir
  // change retargets the count immediately without restarting it.
  always_comb begin
    term_val     = dir ? MAX : '0;
    start_val    = dir ? '0 : MAX;
    at_term      = (q == term_val);
    step_val     = dir ? (q + WIDTH'(1)) : (q - WIDTH'(1));
    wrap_next    = at_term ? start_val : step_val;
    hit_term     = (wrap_next == term_val);
    load_clamped = (load_val > MAX) ? MAX : load_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      state <= IDLE;
    end else begin
      tc <= 1'b0;
      if (load) begin
        q     <= load_clamped;
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (mode != MODE_ONESHOT) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
        // Saturate parks on the terminal value; wrap (and reserved 11) rolls over.
        if (en && !(mode == MODE_SAT && at_term)) begin
          q  <= wrap_next;
          tc <= hit_term;
        end
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              q     <= start_val;
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
          RUN: begin
            if (en) begin
              q <= wrap_next;
              if (hit_term) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                tc    <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - table, directed and random checks of mode_counter
module tb_mode_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic       start;

  logic [3:0] q0;
  logic [7:0] q1;
  logic [3:0] q2;
  logic [7:0] q3;
  logic [3:0] tc_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;

  int n_checks = 0;
  int n_fail   = 0;

  int inst_w [4] = '{4, 8, 4, 8};
  int inst_m [4] = '{9, 255, 5, 100};

  // Model state: phase 0 = idle, 1 = running, 2 = finished
  int mq    [4];
  int mtc   [4];
  int mbusy [4];
  int mdone [4];
  int mph   [4];

  typedef struct {
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [7:0] lv;
    logic       start;
    int         exp_q;
    int         exp_tc;
  } vec_t;

  vec_t tbl[$];

  mode_counter #(.WIDTH(4), .MAX(4'd9)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val[3:0]), .start(start), .q(q0), .tc(tc_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );
  mode_counter #(.WIDTH(8)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .start(start), .q(q1), .tc(tc_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );
  mode_counter #(.WIDTH(4), .MAX(4'd5)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val[3:0]), .start(start), .q(q2), .tc(tc_v[2]),
    .busy(busy_v[2]), .done(done_v[2])
  );
  mode_counter #(.WIDTH(8), .MAX(8'd100)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .start(start), .q(q3), .tc(tc_v[3]),
    .busy(busy_v[3]), .done(done_v[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int get_q(int i);
    case (i)
      0:       return int'(q0);
      1:       return int'(q1);
      2:       return int'(q2);
      default: return int'(q3);
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = 0; mtc[i] = 0; mbusy[i] = 0; mdone[i] = 0; mph[i] = 0;
    end
  endfunction

  function automatic void model_step(int i);
    int m    = inst_m[i];
    int term = dir ? m : 0;
    int sv   = dir ? 0 : m;
    int lv   = int'(load_val) % (1 << inst_w[i]);
    int nxt  = dir ? (mq[i] + 1) % (m + 1) : (mq[i] + m) % (m + 1);
    mtc[i] = 0;
    if (load) begin
      mq[i] = (lv > m) ? m : lv;
      mph[i] = 0; mbusy[i] = 0; mdone[i] = 0;
    end else if (mode != 2'b10) begin
      mph[i] = 0; mbusy[i] = 0; mdone[i] = 0;
      if (en && !(mode == 2'b01 && mq[i] == term)) begin
        mq[i] = nxt;
        mtc[i] = (nxt == term) ? 1 : 0;
      end
    end else if (start && mph[i] != 1) begin
      mq[i] = sv; mph[i] = 1; mbusy[i] = 1; mdone[i] = 0;
    end else if (mph[i] == 1 && en) begin
      mq[i] = nxt;
      if (nxt == term) begin
        mph[i] = 2; mbusy[i] = 0; mdone[i] = 1; mtc[i] = 1;
      end
    end
  endfunction

  task automatic compare_all(string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s u%0d.q", tag, i), get_q(i), mq[i]);
      check($sformatf("%s u%0d.tc", tag, i), int'(tc_v[i]), mtc[i]);
      check($sformatf("%s u%0d.busy", tag, i), int'(busy_v[i]), mbusy[i]);
      check($sformatf("%s u%0d.done", tag, i), int'(done_v[i]), mdone[i]);
    end
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 4; i++) model_step(i);
    end else begin
      model_reset();
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic set_in(logic e, logic d, logic [1:0] m, logic ld, logic [7:0] lv, logic s);
    en = e; dir = d; mode = m; load = ld; load_val = lv; start = s;
  endtask

  function automatic vec_t mk(logic e, logic d, logic [1:0] m, logic ld,
                              logic [7:0] lv, logic s, int eq, int etc);
    vec_t v;
    v.en = e; v.dir = d; v.mode = m; v.load = ld; v.lv = lv; v.start = s;
    v.exp_q = eq; v.exp_tc = etc;
    return v;
  endfunction

  initial begin
    int tc_count;
    int busy_count;

    // Wrap up from reset on u0 (MAX=9), then load 2 and wrap down.
    for (int k = 1; k <= 10; k++) tbl.push_back(mk(1, 1, 2'b00, 0, 8'd0, 0, k % 10, (k == 9) ? 1 : 0));
    tbl.push_back(mk(1, 0, 2'b00, 1, 8'd2, 0, 2, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 8'd0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 8'd0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 2'b00, 0, 8'd0, 0, 9, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 8'd0, 0, 8, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 8'd0, 0, 8, 0));

    set_in(0, 1, 2'b00, 0, 8'd0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      set_in(tbl[k].en, tbl[k].dir, tbl[k].mode, tbl[k].load, tbl[k].lv, tbl[k].start);
      cycle($sformatf("tbl%0d", k));
      check($sformatf("tbl%0d u0.q", k), int'(q0), tbl[k].exp_q);
      check($sformatf("tbl%0d u0.tc", k), int'(tc_v[0]), tbl[k].exp_tc);
    end

    // Saturate on u1 (MAX=255) from 253.
    set_in(1, 1, 2'b01, 1, 8'd253, 0);
    cycle("sat_load");
    check("sat_load u1.q", int'(q1), 253);
    check("sat_load u1.tc", int'(tc_v[1]), 0);
    set_in(1, 1, 2'b01, 0, 8'd0, 0);
    tc_count = 0;
    for (int k = 0; k < 4; k++) begin
      cycle("sat");
      check($sformatf("sat%0d u1.q", k), int'(q1), (k == 0) ? 254 : 255);
      tc_count += int'(tc_v[1]);
    end
    check("sat u1.tc_pulses", tc_count, 1);

    // One-shot on u2 (MAX=5).
    set_in(1, 1, 2'b10, 0, 8'd0, 1);
    cycle("os_start");
    check("os_start u2.q", int'(q2), 0);
    check("os_start u2.busy", int'(busy_v[2]), 1);
    busy_count = int'(busy_v[2]);
    set_in(1, 1, 2'b10, 0, 8'd0, 0);
    for (int k = 1; k <= 7; k++) begin
      cycle("os_run");
      check($sformatf("os%0d u2.q", k), int'(q2), (k < 5) ? k : 5);
      check($sformatf("os%0d u2.done", k), int'(done_v[2]), (k >= 5) ? 1 : 0);
      check($sformatf("os%0d u2.tc", k), int'(tc_v[2]), (k == 5) ? 1 : 0);
      busy_count += int'(busy_v[2]);
    end
    check("os u2.busy_cycles", busy_count, 5);
    set_in(1, 1, 2'b10, 0, 8'd0, 1);
    cycle("os_rearm");
    check("os_rearm u2.q", int'(q2), 0);
    check("os_rearm u2.busy", int'(busy_v[2]), 1);
    check("os_rearm u2.done", int'(done_v[2]), 0);

    // Load beats start; then clamp of an oversize load.
    set_in(1, 1, 2'b10, 1, 8'd3, 1);
    cycle("ld_start");
    check("ld_start u2.q", int'(q2), 3);
    check("ld_start u2.busy", int'(busy_v[2]), 0);
    set_in(1, 1, 2'b10, 0, 8'd0, 0);
    cycle("ld_idle");
    check("ld_idle u2.q", int'(q2), 3);
    set_in(0, 1, 2'b00, 1, 8'd200, 0);
    cycle("clamp");
    check("clamp u3.q", int'(q3), 100);
    check("clamp u3.tc", int'(tc_v[3]), 0);

    // Asynchronous reset mid-run at q=3.
    set_in(1, 1, 2'b10, 0, 8'd0, 1);
    cycle("rst_start");
    set_in(1, 1, 2'b10, 0, 8'd0, 0);
    repeat (3) cycle("rst_run");
    check("rst_run u2.q", int'(q2), 3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    cycle("in_rst");
    rst_n = 1'b1;
    tc_count = 0;
    for (int k = 0; k < 6; k++) begin
      cycle("post_rst");
      tc_count += int'(tc_v[2]);
    end
    check("post_rst u2.q", int'(q2), 0);
    check("post_rst u2.tc_pulses", tc_count, 0);

    // Random stimulus against the model.
    for (int k = 0; k < 600; k++) begin
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 11) == 0);
      start    = ($urandom_range(0, 3) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("rnd_rst");
        rst_n = 1'b1;
      end
      cycle($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter MAX, default 2^WIDTH-1: terminal count, legal range 1..2^WIDTH-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port dir, input, 1 bit: 1 = count up, 0 = count down.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved and treated as wrap.
REQ-008 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 The block SHALL have port load_val, input, WIDTH bits: value to load.
REQ-010 The block SHALL have port start, input, 1 bit: one-shot arm strobe; ignored in the other modes.
REQ-011 The block SHALL have port q, output, WIDTH bits: current count, registered.
REQ-012 The block SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-013 The block SHALL have port busy, output, 1 bit: one-shot running.
REQ-014 The block SHALL have port done, output, 1 bit: one-shot finished; level, held until cleared.

Function
REQ-015 The terminal value SHALL be MAX when dir=1 and 0 when dir=0; the start value SHALL be 0 when dir=1 and MAX when dir=0.
REQ-016 Priority per edge SHALL be: load > start > count step > hold.
REQ-017 On load=1: q <= min(load_val, MAX), tc <= 0, the one-shot FSM goes to IDLE, and done <= 0.
REQ-018 Count step, when en=1 and load=0: q changes by ±1 per dir, with width-exact arithmetic and no intermediate overflow beyond WIDTH bits.
REQ-019 Wrap mode: q at the terminal value SHALL step to the start value (up MAX->0, down 0->MAX).
REQ-020 Saturate mode: q at the terminal value SHALL hold while en=1.
REQ-021 tc SHALL be 1 during exactly the cycle after the edge on which a count step makes q equal to the terminal value; tc SHALL be 0 otherwise.
REQ-022 tc SHALL NOT assert on a load of the terminal value, while saturated and holding, or when en=0.
REQ-023 One-shot FSM states SHALL be IDLE, RUN and DONE.
REQ-024 In IDLE, start=1 (mode=10) SHALL set q <= start value, move to RUN and set busy <= 1.
REQ-025 In RUN with en=1, q SHALL step; on the step that reaches the terminal value, the FSM moves to DONE, busy <= 0, done <= 1 and tc pulses.
REQ-026 In RUN with en=0, q SHALL hold.
REQ-027 In DONE, q SHALL hold; start=1 SHALL re-arm (q <= start value, go to RUN, done <= 0, busy <= 1).
REQ-028 In mode 10, count steps SHALL occur only in RUN.
REQ-029 A dir change SHALL take effect at the next edge, using the new terminal value.
REQ-030 In RUN, a dir change SHALL NOT restart the count.
REQ-031 A mode change away from 10 SHALL force the FSM to IDLE and busy/done to 0 at the next edge; q SHALL be kept.

Reset
REQ-032 rst_n=0 SHALL immediately, without a clock edge, force q=0, tc=0, busy=0, done=0 and FSM=IDLE.
REQ-033 Deassertion of rst_n SHALL take effect at the first clk edge with rst_n=1.
REQ-034 Reset asserted mid-run SHALL abort the one-shot with no tc pulse.

Verification
REQ-035 Wrap up, WIDTH=4, MAX=9, en=1, dir=1, from reset: q = 0,1,...,9,0; tc high only in the cycle q=9.
REQ-036 Wrap down, WIDTH=4, MAX=9, load 2, dir=0: q = 2,1,0,9,8; tc high only in the cycle q=0.
REQ-037 Saturate, WIDTH=8, MAX=255, load 253, dir=1: q = 253,254,255,255,255; tc exactly one pulse.
REQ-038 One-shot, MAX=5, start pulse, en=1: busy 1 for 5 steps, q 0..5, then done=1, q holds 5; second start re-arms with q=0.
REQ-039 Boundary: load_val=200 with MAX=100 -> q=100, tc=0; load and start in the same cycle -> load wins, FSM IDLE.
REQ-040 Reset at q=3 in RUN (asynchronous, mid-cycle) -> q=0, busy=0, done=0 immediately; no tc afterward until a new start.
